// File: rtl/inst_fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response, redirect, decode-side handshake.
// master = the queue, slave = its environment (imem, branch unit, decode).
interface inst_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] stall_cycles;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_plus4, stall_cycles,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_plus4, stall_cycles,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential imem requests and buffers {pc, word} for decode.
// Latency: request in cycle N -> out_valid in N+2; imem_data is registered, never bypassed.
// Backpressure: requests stop when queued + in-flight reaches DEPTH; IFQ_PERF_CNT_EN adds stall_cycles.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 clock,
  input  logic                 reset,
  inst_fetch_queue_if.master   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_fetch_queue: DEPTH must be a power of two in 2..16");
  end

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic [CW-1:0] w_occupancy;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_inst;

  // The in-flight slot is reserved up front, so a returning word always has room.
  assign w_empty     = (r_count == '0);
  assign w_occupancy = r_count + CW'(r_inflight);
  assign w_req       = reset && !bus.redirect && (w_occupancy < CW'(DEPTH));
  assign w_push      = reset && !bus.redirect && r_inflight;
  assign w_pop       = reset && !bus.redirect && !w_empty && bus.out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC & ~32'h3;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc    <= bus.redirect_pc & ~32'h3;
      r_inflight    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_inst[r_wr_ptr] <= bus.imem_data;
      r_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  // Head fields read as zero when empty, which also yields the post-reset output values.
  assign w_head_pc   = w_empty ? 32'h0 : r_pc[r_rd_ptr];
  assign w_head_inst = w_empty ? 32'h0 : r_inst[r_rd_ptr];

  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_fetch_pc;
  assign bus.out_valid    = !w_empty;
  assign bus.out_inst     = w_head_inst;
  assign bus.out_pc       = w_head_pc;
  assign bus.out_pc_plus4 = w_head_pc + 32'd4;

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (bus.out_ready && w_empty && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 32'h0;
`endif

endmodule
